// File: rtl/scsi_sm_pkg.sv
// ============================================================================
//  Module   : scsi_sm_pkg
//  Purpose  : Shared types and constants for the SDMAC SCSI bus sequencer.
//             Provides the state encoding and the direction constants that
//             the CPU-interface and DMA logic use.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package scsi_sm_pkg;

    // Sequencer states, 4-bit encoding
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CR1   = 4'd1,
        CR2   = 4'd2,
        CR3   = 4'd3,
        CW1   = 4'd4,
        CW2   = 4'd5,
        CW3   = 4'd6,
        CDONE = 4'd7,
        DR1   = 4'd8,
        DR2   = 4'd9,
        DR3   = 4'd10,
        DW1   = 4'd11,
        DW2   = 4'd12,
        DW3   = 4'd13
    } state_t;

    // DMADIR encoding
    localparam logic DMADIR_S2F = 1'b0;   // SCSI -> FIFO
    localparam logic DMADIR_F2S = 1'b1;   // FIFO -> SCSI

    // RW encoding for CPU accesses
    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/scsi_sm.sv
// ============================================================================
//  Module   : scsi_sm
//  Purpose  : SDMAC SCSI bus state machine. Sequences CPU register reads and
//             writes to the WD33C93 and single-byte DMA transfers between the
//             WD33C93 and the SDMAC FIFO. Moore machine: all strobes and
//             enables decode from the state register (DR3/DW3 additionally
//             qualify the longword-complete controls with BOEQ3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scsi_sm
    import scsi_sm_pkg::*;
(
    input  logic CPUCLK,
    input  logic RESET_,
    input  logic nAS_,
    input  logic CPUREQ,
    input  logic RW,
    input  logic DMADIR,
    input  logic INCFIFO,
    input  logic DECFIFO,
    input  logic BOEQ3,
    input  logic DREQ_,
    input  logic FIFOFULL,
    input  logic FIFOEMPTY,
    output logic LS2CPU,
    output logic RDFIFO_o,
    output logic RIFIFO_o,
    output logic RE_o,
    output logic WE_o,
    output logic SCSI_CS_o,
    output logic DACK_o,
    output logic INCBO_o,
    output logic INCNO_o,
    output logic INCNI_o,
    output logic S2F_o,
    output logic F2S_o,
    output logic S2CPU_o,
    output logic CPU2S_o
);

    state_t state;
    state_t state_nxt;

    // The address strobe plays no part in sequencing; CPUREQ already
    // qualifies a CPU access upstream.
    logic unused_nas;
    assign unused_nas = nAS_;

    // A DMA byte may start only when the chip requests it and no FIFO count
    // update is still in flight.
    logic dma_ok;
    assign dma_ok = !DREQ_ && !INCFIFO && !DECFIFO;

    // State register; reset forces IDLE (and hence all-zero outputs) at once.
    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: CPU requests win over DMA; RW/DMADIR only matter in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (CPUREQ) begin
                    state_nxt = (RW == RW_READ) ? CR1 : CW1;
                end else if (dma_ok) begin
                    if (DMADIR == DMADIR_S2F && !FIFOFULL) begin
                        state_nxt = DR1;
                    end else if (DMADIR == DMADIR_F2S && !FIFOEMPTY) begin
                        state_nxt = DW1;
                    end
                end
            end
            CR1:     state_nxt = CR2;
            CR2:     state_nxt = CR3;
            CR3:     state_nxt = CDONE;
            CW1:     state_nxt = CW2;
            CW2:     state_nxt = CW3;
            CW3:     state_nxt = CDONE;
            // Hold until the CPU drops its request so one request = one access
            CDONE:   state_nxt = CPUREQ ? CDONE : IDLE;
            DR1:     state_nxt = DR2;
            DR2:     state_nxt = DR3;
            DR3:     state_nxt = IDLE;
            DW1:     state_nxt = DW2;
            DW2:     state_nxt = DW3;
            DW3:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        LS2CPU    = 1'b0;
        RDFIFO_o  = 1'b0;
        RIFIFO_o  = 1'b0;
        RE_o      = 1'b0;
        WE_o      = 1'b0;
        SCSI_CS_o = 1'b0;
        DACK_o    = 1'b0;
        INCBO_o   = 1'b0;
        INCNO_o   = 1'b0;
        INCNI_o   = 1'b0;
        S2F_o     = 1'b0;
        F2S_o     = 1'b0;
        S2CPU_o   = 1'b0;
        CPU2S_o   = 1'b0;
        case (state)
            CR1, CR2: begin
                SCSI_CS_o = 1'b1;
                RE_o      = 1'b1;
                S2CPU_o   = 1'b1;
            end
            CR3: begin
                SCSI_CS_o = 1'b1;
                RE_o      = 1'b1;
                S2CPU_o   = 1'b1;
                LS2CPU    = 1'b1;
            end
            CW1: begin
                // Data is driven one cycle ahead of the write strobe
                SCSI_CS_o = 1'b1;
                CPU2S_o   = 1'b1;
            end
            CW2, CW3: begin
                SCSI_CS_o = 1'b1;
                WE_o      = 1'b1;
                CPU2S_o   = 1'b1;
            end
            DR1, DR2: begin
                DACK_o    = 1'b1;
                RE_o      = 1'b1;
                S2F_o     = 1'b1;
            end
            DR3: begin
                // Fourth byte completes a longword: push it into the FIFO
                INCBO_o   = 1'b1;
                INCNI_o   = BOEQ3;
                RIFIFO_o  = BOEQ3;
            end
            DW1, DW2: begin
                DACK_o    = 1'b1;
                WE_o      = 1'b1;
                F2S_o     = 1'b1;
            end
            DW3: begin
                // Fourth byte drained a longword: pop it from the FIFO
                INCBO_o   = 1'b1;
                INCNO_o   = BOEQ3;
                RDFIFO_o  = BOEQ3;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_scsi_sm.sv
// ============================================================================
//  Module   : tb_scsi_sm
//  Purpose  : Self-checking bench for scsi_sm. Table of per-cycle input
//             records with the expected output vector after the next edge,
//             plus a hand-written mid-sequence reset case.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scsi_sm;

    logic CPUCLK = 1'b0;
    logic RESET_ = 1'b0;
    logic nAS_ = 1'b1, CPUREQ = 1'b0, RW = 1'b0, DMADIR = 1'b0;
    logic INCFIFO = 1'b0, DECFIFO = 1'b0, BOEQ3 = 1'b0, DREQ_ = 1'b1;
    logic FIFOFULL = 1'b0, FIFOEMPTY = 1'b1;
    logic LS2CPU, RDFIFO_o, RIFIFO_o, RE_o, WE_o, SCSI_CS_o, DACK_o;
    logic INCBO_o, INCNO_o, INCNI_o, S2F_o, F2S_o, S2CPU_o, CPU2S_o;

    scsi_sm dut (
        .CPUCLK(CPUCLK), .RESET_(RESET_), .nAS_(nAS_), .CPUREQ(CPUREQ),
        .RW(RW), .DMADIR(DMADIR), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
        .BOEQ3(BOEQ3), .DREQ_(DREQ_), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
        .LS2CPU(LS2CPU), .RDFIFO_o(RDFIFO_o), .RIFIFO_o(RIFIFO_o), .RE_o(RE_o),
        .WE_o(WE_o), .SCSI_CS_o(SCSI_CS_o), .DACK_o(DACK_o), .INCBO_o(INCBO_o),
        .INCNO_o(INCNO_o), .INCNI_o(INCNI_o), .S2F_o(S2F_o), .F2S_o(F2S_o),
        .S2CPU_o(S2CPU_o), .CPU2S_o(CPU2S_o)
    );

    always #5 CPUCLK = ~CPUCLK;

    // Output bit positions
    localparam logic [13:0] B_LS    = 14'h2000;
    localparam logic [13:0] B_RDF   = 14'h1000;
    localparam logic [13:0] B_RIF   = 14'h0800;
    localparam logic [13:0] B_RE    = 14'h0400;
    localparam logic [13:0] B_WE    = 14'h0200;
    localparam logic [13:0] B_CS    = 14'h0100;
    localparam logic [13:0] B_DACK  = 14'h0080;
    localparam logic [13:0] B_INCBO = 14'h0040;
    localparam logic [13:0] B_INCNO = 14'h0020;
    localparam logic [13:0] B_INCNI = 14'h0010;
    localparam logic [13:0] B_S2F   = 14'h0008;
    localparam logic [13:0] B_F2S   = 14'h0004;
    localparam logic [13:0] B_S2CPU = 14'h0002;
    localparam logic [13:0] B_CPU2S = 14'h0001;

    localparam logic [13:0] O_NONE  = 14'h0000;
    localparam logic [13:0] O_CR12  = B_CS | B_RE | B_S2CPU;
    localparam logic [13:0] O_CR3   = B_CS | B_RE | B_S2CPU | B_LS;
    localparam logic [13:0] O_CW1   = B_CS | B_CPU2S;
    localparam logic [13:0] O_CW23  = B_CS | B_WE | B_CPU2S;
    localparam logic [13:0] O_DR12  = B_DACK | B_RE | B_S2F;
    localparam logic [13:0] O_DR3B  = B_INCBO | B_INCNI | B_RIF;
    localparam logic [13:0] O_DW12  = B_DACK | B_WE | B_F2S;
    localparam logic [13:0] O_DW3B  = B_INCBO | B_INCNO | B_RDF;
    localparam logic [13:0] O_INCBO = B_INCBO;

    typedef struct {
        string       name;
        logic        cpureq, rw, dmadir, incfifo, decfifo, boeq3, dreq_n, full, empty;
        logic [13:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        int          idx;
        logic [13:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [13:0] outs();
        return {LS2CPU, RDFIFO_o, RIFIFO_o, RE_o, WE_o, SCSI_CS_o, DACK_o,
                INCBO_o, INCNO_o, INCNI_o, S2F_o, F2S_o, S2CPU_o, CPU2S_o};
    endfunction

    task automatic row(input string nm, input logic cq, input logic rw, input logic dd,
                       input logic incf, input logic decf, input logic bo, input logic dq,
                       input logic fl, input logic em, input logic [13:0] e);
        vec_t v;
        v.name = nm; v.cpureq = cq; v.rw = rw; v.dmadir = dd; v.incfifo = incf;
        v.decfifo = decf; v.boeq3 = bo; v.dreq_n = dq; v.full = fl; v.empty = em;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_invariants(input string nm);
        logic [1:0] v;
        v = {RE_o & WE_o, SCSI_CS_o & DACK_o};
        checks++;
        if (v !== 2'b00) begin
            errors++;
            $display("FAIL %s invariant RE&WE/CS&DACK: got %b expected 00", nm, v);
        end
    endtask

    initial begin
        sb_t s;

        // ---------------- reset state ----------------
        #2;
        check("reset_asserted", outs(), O_NONE);
        @(negedge CPUCLK);
        RESET_ = 1'b1;
        @(posedge CPUCLK); #1;
        check("reset_released_idle", outs(), O_NONE);

        // ---------------- vector table ----------------
        //         name          cq rw dd if df bo dq fl em  expected
        // CPU read, CPUREQ for 6 cycles; RW flips mid-access and is ignored
        row("cr_1",    1, 1, 0, 0, 0, 0, 1, 0, 1, O_CR12);
        row("cr_2",    1, 0, 0, 0, 0, 0, 1, 0, 1, O_CR12);
        row("cr_3",    1, 1, 0, 0, 0, 0, 1, 0, 1, O_CR3);
        row("cr_done", 1, 1, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        row("cr_hold", 1, 1, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        row("cr_hold", 1, 1, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        row("cr_rel",  0, 1, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        row("cr_idle", 0, 1, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        // CPU write, CPUREQ held
        row("cw_1",    1, 0, 0, 0, 0, 0, 1, 0, 1, O_CW1);
        row("cw_2",    1, 0, 0, 0, 0, 0, 1, 0, 1, O_CW23);
        row("cw_3",    1, 0, 0, 0, 0, 0, 1, 0, 1, O_CW23);
        row("cw_done", 1, 0, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        row("cw_hold", 1, 0, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        row("cw_rel",  0, 0, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        // DMA SCSI->FIFO, two back-to-back bytes (BOEQ3=1 then 0)
        row("dr_1",    0, 0, 0, 0, 0, 1, 0, 0, 1, O_DR12);
        row("dr_2",    0, 0, 0, 0, 0, 1, 0, 0, 1, O_DR12);
        row("dr_3b",   0, 0, 0, 0, 0, 1, 0, 0, 1, O_DR3B);
        row("dr_gap",  0, 0, 0, 0, 0, 1, 0, 0, 1, O_NONE);
        row("dr_1",    0, 0, 0, 0, 0, 0, 0, 0, 1, O_DR12);
        row("dr_2",    0, 0, 0, 0, 0, 0, 0, 0, 1, O_DR12);
        row("dr_3n",   0, 0, 0, 0, 0, 0, 0, 0, 1, O_INCBO);
        row("dr_end",  0, 0, 0, 0, 0, 0, 1, 0, 1, O_NONE);
        // FIFO full blocks SCSI->FIFO
        row("dr_full", 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        // DMA FIFO->SCSI; DMADIR flip mid-transfer ignored
        row("dw_1",    0, 0, 1, 0, 0, 1, 0, 0, 0, O_DW12);
        row("dw_2",    0, 0, 0, 0, 0, 1, 0, 0, 0, O_DW12);
        row("dw_3b",   0, 0, 1, 0, 0, 1, 1, 0, 0, O_DW3B);
        row("dw_idle", 0, 0, 1, 0, 0, 1, 1, 0, 0, O_NONE);
        row("dw_1",    0, 0, 1, 0, 0, 0, 0, 0, 0, O_DW12);
        row("dw_2",    0, 0, 1, 0, 0, 0, 0, 0, 0, O_DW12);
        row("dw_3n",   0, 0, 1, 0, 0, 0, 1, 0, 0, O_INCBO);
        // FIFO empty blocks FIFO->SCSI
        row("dw_empty",0, 0, 1, 0, 0, 1, 0, 0, 1, O_NONE);
        row("dw_empty",0, 0, 1, 0, 0, 1, 0, 0, 1, O_NONE);
        // CPU beats DMA on the same edge; DMA serviced after CDONE exits
        row("arb_cr1", 1, 1, 0, 0, 0, 0, 0, 0, 1, O_CR12);
        row("arb_cr2", 1, 1, 0, 0, 0, 0, 0, 0, 1, O_CR12);
        row("arb_cr3", 1, 1, 0, 0, 0, 0, 0, 0, 1, O_CR3);
        row("arb_cdn", 0, 1, 0, 0, 0, 0, 0, 0, 1, O_NONE);
        row("arb_idl", 0, 1, 0, 0, 0, 0, 0, 0, 1, O_NONE);
        row("arb_dr1", 0, 1, 0, 0, 0, 0, 0, 0, 1, O_DR12);
        row("arb_dr2", 0, 1, 0, 0, 0, 0, 0, 0, 1, O_DR12);
        row("arb_dr3", 0, 1, 0, 0, 0, 0, 1, 0, 1, O_INCBO);
        // Pending FIFO count updates block DMA start
        row("incfifo", 0, 0, 0, 1, 0, 0, 0, 0, 1, O_NONE);
        row("incfifo", 0, 0, 0, 1, 0, 0, 0, 0, 1, O_NONE);
        row("decfifo", 0, 0, 0, 0, 1, 0, 0, 0, 1, O_NONE);
        row("unblock", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_DR12);
        row("unb_dr2", 0, 0, 0, 0, 0, 0, 1, 0, 1, O_DR12);
        row("unb_dr3", 0, 0, 0, 0, 0, 0, 1, 0, 1, O_INCBO);
        row("unb_end", 0, 0, 0, 0, 0, 0, 1, 0, 1, O_NONE);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CPUCLK);
            nAS_    = $urandom_range(0, 1);
            CPUREQ  = vecs[i].cpureq;  RW      = vecs[i].rw;
            DMADIR  = vecs[i].dmadir;  INCFIFO = vecs[i].incfifo;
            DECFIFO = vecs[i].decfifo; BOEQ3   = vecs[i].boeq3;
            DREQ_   = vecs[i].dreq_n;  FIFOFULL = vecs[i].full;
            FIFOEMPTY = vecs[i].empty;
            s.name = vecs[i].name; s.idx = i; s.exp = vecs[i].exp;
            sb.push_back(s);
            @(posedge CPUCLK); #1;
            s = sb.pop_front();
            check($sformatf("%s[%0d]", s.name, s.idx), outs(), s.exp);
            check_invariants(s.name);
        end

        // ---------------- reset mid-sequence (during CR2) ----------------
        @(negedge CPUCLK);
        CPUREQ = 1'b1; RW = 1'b1; DREQ_ = 1'b1;
        @(posedge CPUCLK); #1;
        check("mr_cr1", outs(), O_CR12);
        @(posedge CPUCLK); #1;
        check("mr_cr2", outs(), O_CR12);
        #2;
        RESET_ = 1'b0;
        #1;
        check("mr_reset_immediate", outs(), O_NONE);
        @(posedge CPUCLK); #1;
        check("mr_reset_held", outs(), O_NONE);
        @(negedge CPUCLK);
        CPUREQ = 1'b0;
        RESET_ = 1'b1;
        @(posedge CPUCLK); #1;
        check("mr_idle_after_release", outs(), O_NONE);
        @(negedge CPUCLK);
        CPUREQ = 1'b1; RW = 1'b0;
        @(posedge CPUCLK); #1;
        check("mr_fresh_write", outs(), O_CW1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
